jtag_catch_multi: RTL
=====================

Name: jtag_catch_multi

Overview:
Parametrised successor to the single-stream JTAG capture block. Passively snoops TCK/TMS/TDI/TDO on the system clock and tracks the IEEE 1149.1 TAP state machine. It latches each IR scan and packs DR scans into DATA_W-bit RAM words, optionally with the TDO stream interleaved. An optional IR-match filter qualifies which DR scans are stored. Sits between the JTAG pins and the register/RAM/interrupt fabric.

Parameters:
IR_W, 8, instruction register width captured.
DATA_W, 32, RAM word width / packing width.
ADDR_W, 10, RAM address width; frame capacity 2^ADDR_W words.
LEN_W, 16, DR bit-length counter width.
SYNC_STAGES, 2, synchroniser depth on JTAG inputs (>=2).

Ports:
sclk  in  1  system clock; all logic on rising edge.
reset  in  1  asynchronous, active-low reset.
TCK, TMS, TDI, TDO  in  1 each  snooped JTAG pins, asynchronous to sclk.
enable_register_i  in  2  bit0 enables IR capture, bit1 enables DR capture.
capture_tdo_i  in  1  1: store TDO word after each TDI word.
ir_filter_en_i  in  1  1: store DR only when IR_register == ir_filter_i.
ir_filter_i  in  IR_W  IR match value.
clear_int_i  in  1  one-sclk pulse; clears int/missed/overflow.
int_register_o  out  1  frame-complete flag.
IR_register  out  IR_W  last captured instruction.
DATALEN_register_o  out  LEN_W  bit count of last stored DR frame.
words_o  out  ADDR_W+1  RAM words written in last stored frame.
missed_o  out  1  sticky: DR frame completed while int pending.
overflow_o  out  1  sticky: frame exceeded RAM capacity.
INT  out  1  equals int_register_o.
ram_we  out  1  one-sclk write strobe.
ram_waddr  out  ADDR_W  write address.
ram_wdata  out  DATA_W  write data.

Behaviour:
- Reset (reset low, asynchronous): TAP=TEST_LOGIC_RESET, all outputs 0, counters and shift registers 0.
- Inputs pass through SYNC_STAGES flops. TCK rise is detected on the synchronised signal; TMS/TDI/TDO are sampled from the same stage. Requirement: TCK period >= 2*(SYNC_STAGES+4) sclk.
- TAP FSM (16 standard states, encodings 0x0-0xF as in the existing block) advances once per TCK rise using TMS. Five TMS=1 rises reach TEST_LOGIC_RESET from any state.
- IR: on a TCK rise in SHIFT_IR, ir_sr <= {TDI, ir_sr[IR_W-1:1]}. On entry to UPDATE_IR with enable bit0=1, IR_register <= ir_sr. Scans longer than IR_W keep the last IR_W bits.
- DR frame is active when enable bit1=1 and (filter off or IR match), evaluated at CAPTURE_DR. On a TCK rise in SHIFT_DR of an active frame:
  - tdi_word[bitcnt] <= TDI, tdo_word[bitcnt] <= TDO, where bitcnt counts 0..DATA_W-1.
  - len increments and saturates at 2^LEN_W-1.
- Word flush occurs when bitcnt wraps, or at EXIT_1_DR with a partial word (unused MSBs 0). Flush writes the TDI word at addr, then, if capture_tdo_i, the TDO word at addr+1 on the next sclk. One write per sclk. Address starts at 0 per frame and increments per write.
- If a write would exceed 2^ADDR_W-1: suppress it, set overflow_o, continue counting len.
- At UPDATE_DR of an active frame:
  - if int_register_o=0: DATALEN_register_o<=len, words_o<=write count, int_register_o<=1 one sclk after the last write.
  - else: the frame's RAM writes still happen, registers are untouched, missed_o<=1.
- Zero-length DR (CAPTURE->EXIT1 without SHIFT) gives len=0, no writes, int set.
- clear_int_i clears int/missed/overflow. A set in the same cycle wins.
- Entering TEST_LOGIC_RESET mid-frame aborts it: no int, partial word discarded.

Test Plan:
- IR scan 8 bits of 0x25 LSB first, enable=2'b11 -> IR_register=0x25 after UPDATE_IR; no ram_we.
- DR 36 bits, TDI=0xA_1234_5678, TDO=0xB_1111_1111, capture_tdo_i=1 -> RAM[0]=0x12345678, [1]=0x11111111, [2]=0x0000000A, [3]=0x0000000B; DATALEN=36, words_o=4, INT=1.
- Same scan with capture_tdo_i=0, after clear_int -> RAM[0]=0x12345678, [1]=0x0000000A; words_o=2.
- ir_filter_en_i=1, ir_filter_i=0x26, IR=0x25, DR scan -> no ram_we, INT stays 0; set ir_filter_i=0x25 -> frame stored.
- Second DR scan without clear_int -> missed_o=1, DATALEN unchanged. Then clear_int pulse coincident with the next frame completion -> int_register_o=1, missed_o=0.
- ADDR_W=2, 200-bit DR with TDO on -> 4 writes only, overflow_o=1, DATALEN=200. Reset asserted mid-SHIFT_DR -> all outputs 0 immediately, TAP=TEST_LOGIC_RESET.

Source files
------------

// File: rtl/jtag_catch_multi.sv
// Passive JTAG snooper: tracks the TAP controller on sclk, latches IR scans and packs DR scans
// (optionally interleaved with TDO) into DATA_W-bit RAM words.
module jtag_catch_multi #(
  parameter int unsigned IR_W        = 8,
  parameter int unsigned DATA_W      = 32,
  parameter int unsigned ADDR_W      = 10,
  parameter int unsigned LEN_W       = 16,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic              sclk,
  input  logic              reset,
  input  logic              TCK,
  input  logic              TMS,
  input  logic              TDI,
  input  logic              TDO,
  input  logic [1:0]        enable_register_i,
  input  logic              capture_tdo_i,
  input  logic              ir_filter_en_i,
  input  logic [IR_W-1:0]   ir_filter_i,
  input  logic              clear_int_i,
  output logic              int_register_o,
  output logic [IR_W-1:0]   IR_register,
  output logic [LEN_W-1:0]  DATALEN_register_o,
  output logic [ADDR_W:0]   words_o,
  output logic              missed_o,
  output logic              overflow_o,
  output logic              INT,
  output logic              ram_we,
  output logic [ADDR_W-1:0] ram_waddr,
  output logic [DATA_W-1:0] ram_wdata
);

  localparam int unsigned CNT_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;

  typedef enum logic [3:0] {
    StExit2Dr    = 4'h0, StExit1Dr    = 4'h1, StShiftDr  = 4'h2, StPauseDr  = 4'h3,
    StSelectIr   = 4'h4, StUpdateDr   = 4'h5, StCaptureDr = 4'h6, StSelectDr = 4'h7,
    StExit2Ir    = 4'h8, StExit1Ir    = 4'h9, StShiftIr  = 4'hA, StPauseIr  = 4'hB,
    StRunIdle    = 4'hC, StUpdateIr   = 4'hD, StCaptureIr = 4'hE, StTestLogicReset = 4'hF
  } tap_e;

  logic [SYNC_STAGES-1:0] tck_s, tms_s, tdi_s, tdo_s;
  logic                   tck_prev_q;
  tap_e                   tap_q, tap_next;
  logic [IR_W-1:0]        ir_sr_q;
  logic                   active_q;
  logic [CNT_W-1:0]       bitcnt_q;
  logic [LEN_W-1:0]       len_q;
  logic [DATA_W-1:0]      tdi_word_q, tdo_word_q, tdi_new, tdo_new;
  logic [DATA_W-1:0]      wr_tdi_q, wr_tdo_q;
  logic                   pend_tdi_q, pend_tdo_q;
  logic [ADDR_W:0]        wcnt_q;

  logic tck_rise, tms, tdi, tdo, shift_dr, flush, frame_done, int_busy, wr_go, wr_full;

  assign tck_rise   = tck_s[SYNC_STAGES-1] & ~tck_prev_q;
  assign tms        = tms_s[SYNC_STAGES-1];
  assign tdi        = tdi_s[SYNC_STAGES-1];
  assign tdo        = tdo_s[SYNC_STAGES-1];
  assign shift_dr   = tck_rise && (tap_q == StShiftDr) && active_q;
  // Flush on a full word, or on the last shift bit before Exit1-DR (TMS=1).
  assign flush      = shift_dr && ((bitcnt_q == CNT_W'(DATA_W - 1)) || tms);
  assign frame_done = tck_rise && (tap_next == StUpdateDr) && active_q;
  // A clear arriving in the completion cycle frees the slot for this frame.
  assign int_busy   = int_register_o & ~clear_int_i;
  assign wr_go      = pend_tdi_q | pend_tdo_q;
  assign wr_full    = wcnt_q[ADDR_W];
  assign INT        = int_register_o;

  always_comb begin
    tdi_new           = tdi_word_q;
    tdo_new           = tdo_word_q;
    tdi_new[bitcnt_q] = tdi;
    tdo_new[bitcnt_q] = tdo;
  end

  always_comb begin
    tap_next = StTestLogicReset;
    unique case (tap_q)
      StTestLogicReset: tap_next = tms ? StTestLogicReset : StRunIdle;
      StRunIdle:        tap_next = tms ? StSelectDr : StRunIdle;
      StSelectDr:       tap_next = tms ? StSelectIr : StCaptureDr;
      StCaptureDr:      tap_next = tms ? StExit1Dr : StShiftDr;
      StShiftDr:        tap_next = tms ? StExit1Dr : StShiftDr;
      StExit1Dr:        tap_next = tms ? StUpdateDr : StPauseDr;
      StPauseDr:        tap_next = tms ? StExit2Dr : StPauseDr;
      StExit2Dr:        tap_next = tms ? StUpdateDr : StShiftDr;
      StUpdateDr:       tap_next = tms ? StSelectDr : StRunIdle;
      StSelectIr:       tap_next = tms ? StTestLogicReset : StCaptureIr;
      StCaptureIr:      tap_next = tms ? StExit1Ir : StShiftIr;
      StShiftIr:        tap_next = tms ? StExit1Ir : StShiftIr;
      StExit1Ir:        tap_next = tms ? StUpdateIr : StPauseIr;
      StPauseIr:        tap_next = tms ? StExit2Ir : StPauseIr;
      StExit2Ir:        tap_next = tms ? StUpdateIr : StShiftIr;
      StUpdateIr:       tap_next = tms ? StSelectDr : StRunIdle;
      default:          tap_next = StTestLogicReset;
    endcase
  end

  always_ff @(posedge sclk or negedge reset) begin
    if (!reset) begin
      tck_s              <= '0;
      tms_s              <= '0;
      tdi_s              <= '0;
      tdo_s              <= '0;
      tck_prev_q         <= 1'b0;
      tap_q              <= StTestLogicReset;
      ir_sr_q            <= '0;
      active_q           <= 1'b0;
      bitcnt_q           <= '0;
      len_q              <= '0;
      tdi_word_q         <= '0;
      tdo_word_q         <= '0;
      wr_tdi_q           <= '0;
      wr_tdo_q           <= '0;
      pend_tdi_q         <= 1'b0;
      pend_tdo_q         <= 1'b0;
      wcnt_q             <= '0;
      int_register_o     <= 1'b0;
      IR_register        <= '0;
      DATALEN_register_o <= '0;
      words_o            <= '0;
      missed_o           <= 1'b0;
      overflow_o         <= 1'b0;
      ram_we             <= 1'b0;
      ram_waddr          <= '0;
      ram_wdata          <= '0;
    end else begin
      tck_s      <= {tck_s[SYNC_STAGES-2:0], TCK};
      tms_s      <= {tms_s[SYNC_STAGES-2:0], TMS};
      tdi_s      <= {tdi_s[SYNC_STAGES-2:0], TDI};
      tdo_s      <= {tdo_s[SYNC_STAGES-2:0], TDO};
      tck_prev_q <= tck_s[SYNC_STAGES-1];
      ram_we     <= 1'b0;

      int_register_o <= (int_register_o & ~clear_int_i) | (frame_done & ~int_busy);
      missed_o       <= (missed_o & ~clear_int_i) | (frame_done & int_busy);
      overflow_o     <= (overflow_o & ~clear_int_i) | (wr_go & wr_full);

      // Drain pending words one per sclk; TDI word always precedes its TDO word.
      if (wr_go) begin
        if (pend_tdi_q) pend_tdi_q <= 1'b0;
        else            pend_tdo_q <= 1'b0;
        if (!wr_full) begin
          ram_we    <= 1'b1;
          ram_waddr <= wcnt_q[ADDR_W-1:0];
          ram_wdata <= pend_tdi_q ? wr_tdi_q : wr_tdo_q;
          wcnt_q    <= wcnt_q + 1'b1;
        end
      end

      if (tck_rise) begin
        tap_q <= tap_next;
        if (tap_q == StShiftIr) ir_sr_q <= {tdi, ir_sr_q[IR_W-1:1]};
        if (tap_next == StUpdateIr && enable_register_i[0]) IR_register <= ir_sr_q;

        if (tap_next == StCaptureDr) begin
          active_q   <= enable_register_i[1] &&
                        (!ir_filter_en_i || (IR_register == ir_filter_i));
          bitcnt_q   <= '0;
          len_q      <= '0;
          tdi_word_q <= '0;
          tdo_word_q <= '0;
          wcnt_q     <= '0;
        end

        if (shift_dr) begin
          if (len_q != '1) len_q <= len_q + 1'b1;
          if (flush) begin
            bitcnt_q   <= '0;
            tdi_word_q <= '0;
            tdo_word_q <= '0;
            wr_tdi_q   <= tdi_new;
            wr_tdo_q   <= tdo_new;
            pend_tdi_q <= 1'b1;
            pend_tdo_q <= capture_tdo_i;
          end else begin
            bitcnt_q   <= bitcnt_q + 1'b1;
            tdi_word_q <= tdi_new;
            tdo_word_q <= tdo_new;
          end
        end

        if (frame_done) begin
          active_q <= 1'b0;
          if (!int_busy) begin
            DATALEN_register_o <= len_q;
            words_o            <= wcnt_q;
          end
        end

        if (tap_next == StTestLogicReset) begin
          active_q   <= 1'b0;
          bitcnt_q   <= '0;
          tdi_word_q <= '0;
          tdo_word_q <= '0;
        end
      end
    end
  end

endmodule
